rd_ptr_sync_ctrl: RTL and testbench
===================================

Name: rd_ptr_sync_ctrl

Overview:
Read-domain control block for the async FIFO. It synchronises the Gray-coded write pointer into i_RD_clk through a parametrised flop chain and owns the read pointer in binary and Gray form. From these it generates registered empty, almost-empty, fill-level and sticky error flags. The block sits between the FIFO RAM read port and the read-side user logic, and supersedes the fixed 2-flop write-pointer synchroniser.

Parameters:
ADDR_W, 8, RAM address width; FIFO depth = 2^ADDR_W; pointers are ADDR_W+1 bits.
SYNC_STAGES, 2, number of synchroniser flops (legal range 2..4; values outside this range are a fatal elaboration error).
AEMPTY_TH, 4, almost-empty threshold in entries (legal range 0..2^ADDR_W-1).

Ports:
i_RD_clk  input  1  read-domain clock
i_RD_rst_n  input  1  asynchronous, active-low reset
i_WR_Ptr_gray  input  ADDR_W+1  Gray write pointer from the write domain (unsynchronised)
i_RD_en  input  1  read request from the user
i_Err_clr  input  1  clears the sticky error flags
o_RD_Addr  output  ADDR_W  RAM read address (lower ADDR_W bits of the binary read pointer)
o_RD_Ptr_gray  output  ADDR_W+1  registered Gray read pointer, sent to the write domain
o_Empty  output  1  FIFO empty
o_Almost_Empty  output  1  level <= AEMPTY_TH
o_Level  output  ADDR_W+1  entries available (0..2^ADDR_W)
o_Underflow  output  1  sticky: a read was attempted while empty
o_Ptr_Err  output  1  sticky: computed level exceeded 2^ADDR_W

Behaviour:
- Reset (async assert, sync release):
  - all sync stages = 0; rd_bin = 0; o_RD_Ptr_gray = 0; o_RD_Addr = 0
  - o_Empty = 1; o_Almost_Empty = 1; o_Level = 0; o_Underflow = 0; o_Ptr_Err = 0
  - Reset mid-operation discards all state immediately; no partial update.
- Sync chain:
  - stage[0] <= i_WR_Ptr_gray; stage[i] <= stage[i-1]
  - wr_sync = stage[SYNC_STAGES-1]
  - No logic is permitted between stages.
- wr_bin = gray2bin(wr_sync), combinational: bit ADDR_W copied, bit i = bit i+1 ^ gray bit i.
- Read accept: rd_ok = i_RD_en & ~o_Empty.
  - rd_bin_next = rd_bin + rd_ok, wrapping modulo 2^(ADDR_W+1).
  - rd_bin, o_RD_Addr and o_RD_Ptr_gray (= rd_bin_next ^ (rd_bin_next>>1)) are all registered from rd_bin_next.
- Flags, registered each cycle from wr_bin and rd_bin_next:
  - lvl = (wr_bin - rd_bin_next) mod 2^(ADDR_W+1)
  - o_Level <= lvl
  - o_Empty <= (bin2gray(rd_bin_next) == wr_sync)
  - o_Almost_Empty <= (lvl <= AEMPTY_TH)
- Latency:
  - An i_WR_Ptr_gray change sampled at rd edge k reaches wr_sync at edge k+SYNC_STAGES-1.
  - Flags and level reflect it at edge k+SYNC_STAGES.
  - A read accepted at edge n updates flags at edge n: no bubble, and back-to-back reads drain the FIFO to empty.
- Simultaneous read accept and wr_sync change: both fold into the same edge's flag computation.
- Underflow:
  - set when i_RD_en & o_Empty; the pointer does not move.
  - sticky until i_Err_clr.
  - If set and clear occur in the same cycle, set wins.
- Ptr_Err:
  - set when lvl > 2^ADDR_W (corrupt or non-Gray write pointer).
  - sticky and cleared the same way as Underflow.
  - The pointer and flags keep operating normally while it is set.
- Wrap-around: the MSB difference between pointers distinguishes full (lvl = 2^ADDR_W) from empty (lvl = 0). Both the binary and the Gray pointer roll over cleanly from 2^(ADDR_W+1)-1 to 0.

Test Plan:
- Reset: ADDR_W=4, SYNC_STAGES=2, hold i_RD_rst_n=0, toggle inputs -> all outputs 0 except o_Empty=1, o_Almost_Empty=1. Assert reset mid-stream -> same values immediately, asynchronously.
- Sync latency: step i_WR_Ptr_gray 0->Gray(3)=00010 at edge k -> o_Empty falls and o_Level=3 at edge k+2. Repeat with SYNC_STAGES=4 -> change appears at edge k+4.
- Drain: level 5, AEMPTY_TH=4, i_RD_en held high -> o_RD_Addr counts 0..4 and o_Level steps 5,4,3,2,1,0. o_Almost_Empty rises once level reaches 4. o_Empty=1 after the 5th accept; a further i_RD_en sets o_Underflow and the address stays at 5.
- Wrap: preload rd_bin=31, wr=Gray(1) -> o_Level=2. After two reads: rd_bin=1, o_RD_Ptr_gray=00001, o_Empty=1.
- Full level: wr=Gray(16), rd=0 -> o_Level=16, o_Ptr_Err=0. Force illegal wr_bin=17 -> o_Ptr_Err=1 and stays set. Pulse i_Err_clr -> clears. Clear and set in the same cycle -> remains 1.
- Concurrent: read accepted on the same edge that the sync output advances by 2 -> o_Level increases net by 1 on that edge.

Source files
------------

// File: rtl/rd_ptr_sync_ctrl.sv
// Read-domain control for the async FIFO: synchronises the Gray write pointer
// into i_RD_clk and owns the read pointer. It produces registered empty,
// almost-empty, fill-level and sticky error flags.
module rd_ptr_sync_ctrl #(
    parameter int unsigned ADDR_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned AEMPTY_TH   = 4
) (
    input  logic              i_RD_clk,
    input  logic              i_RD_rst_n,
    input  logic [ADDR_W:0]   i_WR_Ptr_gray,
    input  logic              i_RD_en,
    input  logic              i_Err_clr,
    output logic [ADDR_W-1:0] o_RD_Addr,
    output logic [ADDR_W:0]   o_RD_Ptr_gray,
    output logic              o_Empty,
    output logic              o_Almost_Empty,
    output logic [ADDR_W:0]   o_Level,
    output logic              o_Underflow,
    output logic              o_Ptr_Err
);

    localparam int unsigned    PW    = ADDR_W + 1;
    localparam logic [PW-1:0]  DEPTH = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [PW-1:0]  AE_TH = PW'(AEMPTY_TH);

    // Reject parameterisations the synchroniser or flag logic cannot honour.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4) begin : g_bad_sync_stages
        $fatal(1, "rd_ptr_sync_ctrl: SYNC_STAGES must be in 2..4");
    end
    if (AEMPTY_TH >= (32'd1 << ADDR_W)) begin : g_bad_aempty_th
        $fatal(1, "rd_ptr_sync_ctrl: AEMPTY_TH must be below 2**ADDR_W");
    end

    logic [PW-1:0]     sync_q [SYNC_STAGES];
    logic [PW-1:0]     sync_d [SYNC_STAGES];
    logic [PW-1:0]     wr_sync;
    logic [PW-1:0]     wr_bin;

    logic [PW-1:0]     rd_bin_q,  rd_bin_d;
    logic [PW-1:0]     rd_gray_q, rd_gray_d;
    logic [PW-1:0]     level_q,   level_d;
    logic              empty_q,   empty_d;
    logic              aempty_q,  aempty_d;
    logic              underflow_q, underflow_d;
    logic              ptr_err_q,   ptr_err_d;

    logic              rd_ok;
    logic [PW-1:0]     lvl;

    // Synchroniser chain: pure wiring between stages, no logic in the path.
    always_comb begin
        sync_d[0] = i_WR_Ptr_gray;
        for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
    end

    // Synchroniser flops.
    always_ff @(posedge i_RD_clk or negedge i_RD_rst_n) begin
        if (!i_RD_rst_n) begin
            sync_q <= '{default: '0};
        end else begin
            sync_q <= sync_d;
        end
    end

    assign wr_sync = sync_q[SYNC_STAGES-1];

    // Gray to binary: each binary bit is the XOR of all Gray bits at or above it.
    always_comb begin
        wr_bin = '0;
        for (int unsigned i = 0; i < PW; i++) begin
            wr_bin[i] = ^(wr_sync >> i);
        end
    end

    // Read accept, next pointer and flag computation.
    // Flags use the post-read pointer so an accepted read updates them on the same edge.
    always_comb begin
        rd_ok       = i_RD_en & ~empty_q;
        rd_bin_d    = rd_bin_q + {{ADDR_W{1'b0}}, rd_ok};
        rd_gray_d   = rd_bin_d ^ (rd_bin_d >> 1);
        lvl         = wr_bin - rd_bin_d;
        level_d     = lvl;
        empty_d     = (rd_gray_d == wr_sync);
        aempty_d    = (lvl <= AE_TH);
        underflow_d = (i_RD_en & empty_q) | (underflow_q & ~i_Err_clr);
        ptr_err_d   = (lvl > DEPTH) | (ptr_err_q & ~i_Err_clr);
    end

    // Pointer and flag registers.
    always_ff @(posedge i_RD_clk or negedge i_RD_rst_n) begin
        if (!i_RD_rst_n) begin
            rd_bin_q    <= '0;
            rd_gray_q   <= '0;
            level_q     <= '0;
            empty_q     <= 1'b1;
            aempty_q    <= 1'b1;
            underflow_q <= 1'b0;
            ptr_err_q   <= 1'b0;
        end else begin
            rd_bin_q    <= rd_bin_d;
            rd_gray_q   <= rd_gray_d;
            level_q     <= level_d;
            empty_q     <= empty_d;
            aempty_q    <= aempty_d;
            underflow_q <= underflow_d;
            ptr_err_q   <= ptr_err_d;
        end
    end

    assign o_RD_Addr      = rd_bin_q[ADDR_W-1:0];
    assign o_RD_Ptr_gray  = rd_gray_q;
    assign o_Empty        = empty_q;
    assign o_Almost_Empty = aempty_q;
    assign o_Level        = level_q;
    assign o_Underflow    = underflow_q;
    assign o_Ptr_Err      = ptr_err_q;

endmodule

// File: tb/tb_rd_ptr_sync_ctrl.sv
// Bench for rd_ptr_sync_ctrl: two instances (2 and 4 sync stages) share
// stimulus. It uses a directed vector table, hand-written corner sequences and
// randomized traffic, all checked against an arithmetic reference model.
module tb_rd_ptr_sync_ctrl;

    localparam int unsigned AW    = 4;
    localparam int unsigned PW    = AW + 1;
    localparam int unsigned MODN  = 32;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned TH    = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic [PW-1:0] wr_gray;
    logic rd_en, err_clr;

    logic [1:0][AW-1:0] addr_o;
    logic [1:0][PW-1:0] gray_o;
    logic [1:0][PW-1:0] level_o;
    logic [1:0]         empty_o, aempty_o, uf_o, perr_o;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    rd_ptr_sync_ctrl #(.ADDR_W(AW), .SYNC_STAGES(2), .AEMPTY_TH(TH)) u_dut_s2 (
        .i_RD_clk(clk), .i_RD_rst_n(rst_n), .i_WR_Ptr_gray(wr_gray),
        .i_RD_en(rd_en), .i_Err_clr(err_clr),
        .o_RD_Addr(addr_o[0]), .o_RD_Ptr_gray(gray_o[0]), .o_Empty(empty_o[0]),
        .o_Almost_Empty(aempty_o[0]), .o_Level(level_o[0]),
        .o_Underflow(uf_o[0]), .o_Ptr_Err(perr_o[0])
    );

    rd_ptr_sync_ctrl #(.ADDR_W(AW), .SYNC_STAGES(4), .AEMPTY_TH(TH)) u_dut_s4 (
        .i_RD_clk(clk), .i_RD_rst_n(rst_n), .i_WR_Ptr_gray(wr_gray),
        .i_RD_en(rd_en), .i_Err_clr(err_clr),
        .o_RD_Addr(addr_o[1]), .o_RD_Ptr_gray(gray_o[1]), .o_Empty(empty_o[1]),
        .o_Almost_Empty(aempty_o[1]), .o_Level(level_o[1]),
        .o_Underflow(uf_o[1]), .o_Ptr_Err(perr_o[1])
    );

    // ---------------- reference model ----------------
    int unsigned   m_stages [2] = '{2, 4};
    int unsigned   m_rd     [2];
    int unsigned   m_level  [2];
    bit            m_empty  [2];
    bit            m_aempty [2];
    bit            m_uf     [2];
    bit            m_perr   [2];
    logic [PW-1:0] samp_q   [$];   // write-pointer samples taken at each edge since reset

    function automatic logic [PW-1:0] gray_of(input int unsigned v);
        logic [PW-1:0] b;
        b = PW'(v % MODN);
        return b ^ (b >> 1);
    endfunction

    function automatic int unsigned bin_of(input logic [PW-1:0] g);
        int unsigned b = 0;
        for (int i = PW - 1; i >= 0; i--) b = (b << 1) | ((b & 1) ^ int'(g[i]));
        return b;
    endfunction

    task automatic model_reset();
        samp_q.delete();
        for (int d = 0; d < 2; d++) begin
            m_rd[d] = 0; m_level[d] = 0; m_empty[d] = 1'b1; m_aempty[d] = 1'b1;
            m_uf[d] = 1'b0; m_perr[d] = 1'b0;
        end
    endtask

    task automatic model_edge();
        for (int d = 0; d < 2; d++) begin
            logic [PW-1:0] ws;
            int unsigned wb, lvl, sz;
            bit ok, uf_set;
            sz = samp_q.size();
            ws = (sz >= m_stages[d]) ? samp_q[sz - m_stages[d]] : '0;
            wb = bin_of(ws);
            ok     = rd_en && !m_empty[d];
            uf_set = rd_en && m_empty[d];
            m_rd[d]     = (m_rd[d] + (ok ? 1 : 0)) % MODN;
            lvl         = (wb + MODN - m_rd[d]) % MODN;
            m_level[d]  = lvl;
            m_empty[d]  = (wb == m_rd[d]);
            m_aempty[d] = (lvl <= TH);
            m_uf[d]     = uf_set || (m_uf[d] && !err_clr);
            m_perr[d]   = (lvl > DEPTH) || (m_perr[d] && !err_clr);
        end
        samp_q.push_back(wr_gray);
        if (samp_q.size() > 8) void'(samp_q.pop_front());
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d required=%0d t=%0t", nm, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        for (int d = 0; d < 2; d++) begin
            string p;
            p = $sformatf("model_s%0d", m_stages[d]);
            chk({p, "_addr"},   addr_o[d],   m_rd[d] % DEPTH);
            chk({p, "_gray"},   gray_o[d],   gray_of(m_rd[d]));
            chk({p, "_level"},  level_o[d],  m_level[d]);
            chk({p, "_empty"},  empty_o[d],  m_empty[d]);
            chk({p, "_aempty"}, aempty_o[d], m_aempty[d]);
            chk({p, "_uf"},     uf_o[d],     m_uf[d]);
            chk({p, "_perr"},   perr_o[d],   m_perr[d]);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        for (int d = 0; d < 2; d++) begin
            string p;
            p = $sformatf("%s_s%0d", tag, m_stages[d]);
            chk({p, "_addr"},   addr_o[d],   0);
            chk({p, "_gray"},   gray_o[d],   0);
            chk({p, "_level"},  level_o[d],  0);
            chk({p, "_empty"},  empty_o[d],  1);
            chk({p, "_aempty"}, aempty_o[d], 1);
            chk({p, "_uf"},     uf_o[d],     0);
            chk({p, "_perr"},   perr_o[d],   0);
        end
    endtask

    task automatic cycle(input logic [PW-1:0] g, input logic re, input logic clr);
        wr_gray = g; rd_en = re; err_clr = clr;
        @(posedge clk);
        model_edge();
        #1;
        compare_model();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0; wr_gray = '0; rd_en = 1'b0; err_clr = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic async_rst();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_vals("midrst");
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // ---------------- directed drain table ----------------
    typedef struct {
        logic [PW-1:0] g;
        logic          re;
        logic          clr;
        int unsigned   lvl;
        logic          emp;
        logic          ae;
        int unsigned   addr;
        logic          uf;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int unsigned wr_cnt;

        // Drain of 5 entries (Gray(5) = 00111) through the 2-stage instance.
        tbl[0] = '{5'b00111, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0};
        tbl[1] = '{5'b00111, 1'b0, 1'b0, 0, 1'b1, 1'b1, 0, 1'b0};
        tbl[2] = '{5'b00111, 1'b0, 1'b0, 5, 1'b0, 1'b0, 0, 1'b0};
        tbl[3] = '{5'b00111, 1'b1, 1'b0, 4, 1'b0, 1'b1, 1, 1'b0};
        tbl[4] = '{5'b00111, 1'b1, 1'b0, 3, 1'b0, 1'b1, 2, 1'b0};
        tbl[5] = '{5'b00111, 1'b1, 1'b0, 2, 1'b0, 1'b1, 3, 1'b0};
        tbl[6] = '{5'b00111, 1'b1, 1'b0, 1, 1'b0, 1'b1, 4, 1'b0};
        tbl[7] = '{5'b00111, 1'b1, 1'b0, 0, 1'b1, 1'b1, 5, 1'b0};
        tbl[8] = '{5'b00111, 1'b1, 1'b0, 0, 1'b1, 1'b1, 5, 1'b1};
        tbl[9] = '{5'b00111, 1'b0, 1'b1, 0, 1'b1, 1'b1, 5, 1'b0};

        rst_n = 1'b0; wr_gray = '0; rd_en = 1'b0; err_clr = 1'b0;
        model_reset();

        // Reset held while inputs toggle.
        for (int i = 0; i < 3; i++) begin
            wr_gray = PW'($urandom_range(0, 31));
            rd_en   = 1'(i);
            err_clr = 1'(~i);
            @(posedge clk);
            #1;
            chk_reset_vals("rst_hold");
        end
        do_reset();

        for (int i = 0; i < 10; i++) begin
            cycle(tbl[i].g, tbl[i].re, tbl[i].clr);
            chk($sformatf("tbl%0d_level", i), level_o[0],  tbl[i].lvl);
            chk($sformatf("tbl%0d_empty", i), empty_o[0],  tbl[i].emp);
            chk($sformatf("tbl%0d_aempty", i), aempty_o[0], tbl[i].ae);
            chk($sformatf("tbl%0d_addr", i),  addr_o[0],   tbl[i].addr);
            chk($sformatf("tbl%0d_uf", i),    uf_o[0],     tbl[i].uf);
        end

        // Sync latency: Gray(3) = 00010 presented at edge k.
        do_reset();
        for (int e = 0; e <= 4; e++) begin
            cycle(5'b00010, 1'b0, 1'b0);
            chk($sformatf("lat_s2_empty_k%0d", e), empty_o[0], (e < 2) ? 1 : 0);
            chk($sformatf("lat_s4_empty_k%0d", e), empty_o[1], (e < 4) ? 1 : 0);
        end
        chk("lat_s2_level", level_o[0], 3);
        chk("lat_s4_level", level_o[1], 3);

        // Concurrent: write pointer advances by 2 on the edge a read is accepted.
        cycle(gray_of(5), 1'b0, 1'b0);
        cycle(gray_of(5), 1'b0, 1'b0);
        chk("conc_before_level", level_o[0], 3);
        cycle(gray_of(5), 1'b1, 1'b0);
        chk("conc_net_level", level_o[0], 4);

        // Underflow: set wins over a simultaneous clear.
        do_reset();
        cycle('0, 1'b1, 1'b0);
        chk("uf_set_s2", uf_o[0], 1);
        cycle('0, 1'b1, 1'b1);
        chk("uf_setwins_s2", uf_o[0], 1);
        cycle('0, 1'b0, 1'b1);
        chk("uf_clr_s2", uf_o[0], 0);

        // Full level, illegal pointer, sticky Ptr_Err and its clearing.
        repeat (5) cycle(gray_of(16), 1'b0, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("full_level_%0d", d), level_o[d], 16);
            chk($sformatf("full_perr_%0d", d),  perr_o[d],  0);
            chk($sformatf("full_empty_%0d", d), empty_o[d], 0);
        end
        repeat (5) cycle(gray_of(17), 1'b0, 1'b0);
        chk("perr_set_s2", perr_o[0], 1);
        chk("perr_set_s4", perr_o[1], 1);
        repeat (5) cycle(gray_of(16), 1'b0, 1'b0);
        chk("perr_sticky_s2", perr_o[0], 1);
        chk("perr_sticky_s4", perr_o[1], 1);
        cycle(gray_of(16), 1'b0, 1'b1);
        chk("perr_clr_s2", perr_o[0], 0);
        chk("perr_clr_s4", perr_o[1], 0);
        repeat (5) cycle(gray_of(17), 1'b0, 1'b1);
        chk("perr_setwins_s2", perr_o[0], 1);
        chk("perr_setwins_s4", perr_o[1], 1);

        // Wrap-around of binary and Gray read pointers.
        do_reset();
        for (int v = 1; v <= 31; v++) cycle(gray_of(v), 1'b1, 1'b0);
        repeat (6) cycle(gray_of(31), 1'b1, 1'b0);
        chk("wrap_pre_gray", gray_o[0], 5'b10000);
        chk("wrap_pre_addr", addr_o[0], 15);
        repeat (5) cycle(gray_of(33), 1'b0, 1'b0);
        chk("wrap_level_s2", level_o[0], 2);
        chk("wrap_level_s4", level_o[1], 2);
        repeat (2) cycle(gray_of(33), 1'b1, 1'b0);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("wrap_gray_%0d", d),  gray_o[d],  5'b00001);
            chk($sformatf("wrap_addr_%0d", d),  addr_o[d],  1);
            chk($sformatf("wrap_empty_%0d", d), empty_o[d], 1);
        end

        // Randomised traffic with occasional corrupt pointers and a mid-stream reset.
        do_reset();
        wr_cnt = 0;
        for (int n = 0; n < 800; n++) begin
            int unsigned r, inc;
            logic [PW-1:0] g;
            bit legal;
            if (n == 400) begin
                async_rst();
                wr_cnt = 0;
            end
            r   = $urandom_range(0, 99);
            inc = (r < 40) ? 1 : (r < 50) ? 2 : 0;
            legal = 1'b1;
            for (int d = 0; d < 2; d++)
                if (((wr_cnt + inc + MODN - m_rd[d]) % MODN) > DEPTH) legal = 1'b0;
            if (legal) wr_cnt = (wr_cnt + inc) % MODN;
            g = gray_of(wr_cnt);
            if ($urandom_range(0, 99) < 2) g = PW'($urandom_range(0, 31));
            cycle(g, 1'($urandom_range(0, 99) < 55), 1'($urandom_range(0, 99) < 5));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
